// File: rtl/multrom_pkg.sv
// Shared types and ROM-content helper for the serial ROM-based multiplier.
package multrom_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} multrom_state_e;

  // Contents of one digit-pair ROM entry.
  function automatic int unsigned digit_prod(input int unsigned a, input int unsigned b);
    return a * b;
  endfunction

endpackage

// File: rtl/multrom_digit_rom.sv
// Constant digit-pair product table, indexed by {a_digit, b_digit}.
module multrom_digit_rom
  import multrom_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH = 4
) (
  input  logic [DIGIT_WIDTH-1:0]   a_digit_i,
  input  logic [DIGIT_WIDTH-1:0]   b_digit_i,
  output logic [2*DIGIT_WIDTH-1:0] prod_c_o
);

  localparam int unsigned PW      = 2 * DIGIT_WIDTH;
  localparam int unsigned ENTRIES = 1 << PW;
  localparam int unsigned RADIX   = 1 << DIGIT_WIDTH;

  logic [PW-1:0] rom [ENTRIES];

  for (genvar k = 0; k < ENTRIES; k++) begin : g_rom
    assign rom[k] = PW'(digit_prod(k / RADIX, k % RADIX));
  end

  assign prod_c_o = rom[{a_digit_i, b_digit_i}];

endmodule

// File: rtl/serial_multrom_mult_param.sv
// Serial multiplier: one digit-pair ROM lookup per cycle, shift-accumulated into a 2*WIDTH result.
// Optional two's-complement mode is built when MULTROM_SIGNED_EN is defined.
module serial_multrom_mult_param
  import multrom_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH = 4,
  parameter int unsigned NUM_DIGITS  = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [DIGIT_WIDTH*NUM_DIGITS-1:0]   mult1,
  input  logic [DIGIT_WIDTH*NUM_DIGITS-1:0]   mult2,
`ifdef MULTROM_SIGNED_EN
  input  logic                                is_signed,
`endif
  output logic                                busy,
  output logic                                done,
  output logic [2*DIGIT_WIDTH*NUM_DIGITS-1:0] dout
);

  localparam int unsigned WIDTH = DIGIT_WIDTH * NUM_DIGITS;
  localparam int unsigned AW    = 2 * WIDTH;
  localparam int unsigned CW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  multrom_state_e state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    acc_q, dout_q;
  logic [CW-1:0]    i_q, j_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0]         a_in, b_in;
  logic [AW-1:0]            result;
  logic [DIGIT_WIDTH-1:0]   a_dig, b_dig;
  logic [2*DIGIT_WIDTH-1:0] prod;
  logic [AW-1:0]            partial;

`ifdef MULTROM_SIGNED_EN
  logic sign_in, sign_q;

  // Signed operands are reduced to magnitudes at capture; the most negative value maps to itself.
  always_comb begin
    a_in    = mult1;
    b_in    = mult2;
    sign_in = 1'b0;
    if (is_signed) begin
      if (mult1[WIDTH-1]) a_in = -mult1;
      if (mult2[WIDTH-1]) b_in = -mult2;
      sign_in = mult1[WIDTH-1] ^ mult2[WIDTH-1];
    end
  end

  assign result = sign_q ? -acc_q : acc_q;
`else
  assign a_in   = mult1;
  assign b_in   = mult2;
  assign result = acc_q;
`endif

  assign a_dig   = DIGIT_WIDTH'(a_q >> (DIGIT_WIDTH * 32'(i_q)));
  assign b_dig   = DIGIT_WIDTH'(b_q >> (DIGIT_WIDTH * 32'(j_q)));
  assign partial = AW'(prod) << (DIGIT_WIDTH * (32'(i_q) + 32'(j_q)));

  multrom_digit_rom #(
    .DIGIT_WIDTH(DIGIT_WIDTH)
  ) u_rom (
    .a_digit_i(a_dig),
    .b_digit_i(b_dig),
    .prod_c_o (prod)
  );

  // Control FSM, digit counters, accumulator and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULTROM_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef MULTROM_SIGNED_EN
            sign_q  <= sign_in;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_q + partial;
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              i_q     <= '0;
              state_q <= DONE;
            end else begin
              i_q <= i_q + CW'(1);
            end
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
        DONE: begin
          dout_q  <= result;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule
